mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared cache-to-memory line bus (the command/address/data bus feeding the memory controller). It lets two caches (e.g. instruction and data, or two cores) share one memory controller. It grants the bus round-robin and locks it for a whole line transaction, so address, write beats and read beats are never interleaved. Requester and memory sides use split unidirectional signals; any tri-state bus adaption lives outside this block.

---
 rtl/bus_pkg.sv | 39 +++
 rtl/mem_bus_arbiter_rr_pick2.sv | 13 +
 rtl/mem_bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the cache-to-memory line bus: C2 command encoding,
// bus widths and the arbiter state encoding.
package bus_pkg;

  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned LINE_BEATS = 16;
  localparam int unsigned CNT_W      = $clog2(LINE_BEATS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } c2_cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WBURST,
    S_WAIT,
    S_RBURST,
    S_DONE
  } arb_state_e;

  // Transaction latched when the bus is granted.
  typedef struct packed {
    logic              owner;
    c2_cmd_e           cmd;
    logic [ADDR_W-1:0] addr;
  } xact_t;

  function automatic logic is_line_req(logic [1:0] cmd);
    return (cmd == C2_READ_LINE) || (cmd == C2_WRITE_LINE);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: on contention the pointer names the winner,
// otherwise the sole requester wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       idx_c,
  output logic       valid_c
);

  assign valid_c = |req;
  assign idx_c   = (&req) ? ptr : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter and line-transaction sequencer for the shared
// cache-to-memory bus; the bus stays locked to one owner for a whole line.
module mem_bus_arbiter
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        r0_cmd,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [1:0]        r1_cmd,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r0_wack,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  output logic              r1_gnt,
  output logic              r1_wack,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic [1:0]        m_cmd,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_resp,
  input  logic [DATA_W-1:0] m_rdata
);

  arb_state_e        state_q, state_d;
  xact_t             xact_q, xact_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              last_q, last_d;
  logic              capture;

  logic              gnt_d, wack_d, done_d;
  c2_cmd_e           m_cmd_d, m_cmd_q;
  logic [ADDR_W-1:0] m_addr_d, m_addr_q;

  logic [1:0]        gnt_q, wack_q, rvalid_q, done_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  logic              pick_idx, pick_valid;

  rr_pick2 u_pick (
    .req     ({is_line_req(r1_cmd), is_line_req(r0_cmd)}),
    .ptr     (ptr_q),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  // Next-state, beat counting and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    xact_d  = xact_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          state_d     = S_ISSUE;
          xact_d.owner = pick_idx;
          xact_d.cmd  = c2_cmd_e'(pick_idx ? r1_cmd : r0_cmd);
          xact_d.addr = pick_idx ? r1_addr : r0_addr;
          cnt_d       = '0;
        end
      end
      S_ISSUE: begin
        // ISSUE carries write beat 0, so the burst resumes at beat 1.
        if (xact_q.cmd == C2_WRITE_LINE) begin
          state_d = S_WBURST;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WBURST: begin
        if (cnt_q == CNT_LAST) state_d = S_WAIT;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WAIT: begin
        if (m_resp) begin
          if (xact_q.cmd == C2_WRITE_LINE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RBURST;
            capture = 1'b1;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_RBURST: begin
        // last_q holds one extra cycle so DONE follows the visible last beat.
        if (last_q) begin
          state_d = S_DONE;
        end else if (m_resp) begin
          capture = 1'b1;
          if (cnt_q == CNT_LAST) last_d = 1'b1;
          else                   cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = ~xact_q.owner;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    gnt_d    = (state_d != S_IDLE);
    wack_d   = ((state_d == S_ISSUE) && (xact_d.cmd == C2_WRITE_LINE)) ||
               (state_d == S_WBURST);
    done_d   = (state_d == S_DONE);
    m_cmd_d  = C2_NOP;
    m_addr_d = '0;
    if ((state_d == S_ISSUE) || (state_d == S_WBURST)) begin
      m_cmd_d  = xact_d.cmd;
      m_addr_d = xact_d.addr;
    end
  end

  // State register plus registered, owner-steered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      xact_q   <= '0;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      last_q   <= 1'b0;
      gnt_q    <= '0;
      wack_q   <= '0;
      rvalid_q <= '0;
      done_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      m_cmd_q  <= C2_NOP;
      m_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      xact_q   <= xact_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      last_q   <= last_d;
      gnt_q    <= {gnt_d  &  xact_d.owner, gnt_d  & ~xact_d.owner};
      wack_q   <= {wack_d &  xact_d.owner, wack_d & ~xact_d.owner};
      done_q   <= {done_d &  xact_d.owner, done_d & ~xact_d.owner};
      rvalid_q <= {capture & xact_q.owner, capture & ~xact_q.owner};
      rdata0_q <= (capture && !xact_q.owner) ? m_rdata : '0;
      rdata1_q <= (capture &&  xact_q.owner) ? m_rdata : '0;
      m_cmd_q  <= m_cmd_d;
      m_addr_q <= m_addr_d;
    end
  end

  assign r0_gnt    = gnt_q[0];
  assign r1_gnt    = gnt_q[1];
  assign r0_wack   = wack_q[0];
  assign r1_wack   = wack_q[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_done   = done_q[0];
  assign r1_done   = done_q[1];
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign m_cmd     = m_cmd_q;
  assign m_addr    = m_addr_q;

  // Write data passes straight through from the owner while it is acknowledged.
  assign m_wdata = wack_q[1] ? r1_wdata : (wack_q[0] ? r0_wdata : '0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a requester/memory model drives
// line transactions and a negedge monitor checks beats against a scoreboard.
module tb_mem_bus_arbiter;

  logic        clk, rst_n;
  logic [1:0]  r0_cmd, r1_cmd;
  logic [14:0] r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic        r0_gnt, r0_wack, r0_rvalid, r0_done;
  logic        r1_gnt, r1_wack, r1_rvalid, r1_done;
  logic [15:0] r0_rdata, r1_rdata;
  logic [1:0]  m_cmd;
  logic [14:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_resp;
  logic [15:0] m_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_owner = 0;
  logic [14:0] exp_addr = '0;
  int          rbeats = 0;
  logic [15:0] rq[$];
  logic [15:0] wq[$];
  logic [19:0] mon_other;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_cmd(r0_cmd), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_cmd(r1_cmd), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r0_wack(r0_wack), .r0_rvalid(r0_rvalid),
    .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_gnt(r1_gnt), .r1_wack(r1_wack), .r1_rvalid(r1_rvalid),
    .r1_rdata(r1_rdata), .r1_done(r1_done),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_resp(m_resp), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_gnt(input int r);
    return (r == 1) ? r1_gnt : r0_gnt;
  endfunction

  function automatic logic get_wack(input int r);
    return (r == 1) ? r1_wack : r0_wack;
  endfunction

  function automatic logic get_done(input int r);
    return (r == 1) ? r1_done : r0_done;
  endfunction

  function automatic logic any_out();
    return |{r0_gnt, r0_wack, r0_rvalid, r0_done, r0_rdata,
             r1_gnt, r1_wack, r1_rvalid, r1_done, r1_rdata,
             m_cmd, m_addr, m_wdata};
  endfunction

  task automatic set_req(input int r, input logic [1:0] c, input logic [14:0] a);
    if (r == 1) begin r1_cmd = c; r1_addr = a; end
    else        begin r0_cmd = c; r0_addr = a; end
  endtask

  task automatic set_wdata(input int r, input logic [15:0] d);
    if (r == 1) r1_wdata = d;
    else        r0_wdata = d;
  endtask

  // Scoreboard side: read beats and write beats are compared in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (r0_rvalid || r1_rvalid) begin
        check("rvalid_owner", {r1_rvalid, r0_rvalid}, (exp_owner == 1) ? 2'b10 : 2'b01);
        if (rq.size() == 0) check("rd_extra_beat", 1, 0);
        else check("rdata", (exp_owner == 1) ? r1_rdata : r0_rdata, rq.pop_front());
        rbeats++;
      end
      if (m_cmd == 2'd3) begin
        if (wq.size() == 0) check("wr_extra_beat", 1, 0);
        else check("m_wdata", m_wdata, wq.pop_front());
        check("owner_wack", get_wack(exp_owner), 1);
      end
      if (m_cmd != 2'd0) check("m_addr_latched", m_addr, exp_addr);
      mon_other = (exp_owner == 1) ? {r0_gnt, r0_wack, r0_rvalid, r0_done, r0_rdata}
                                   : {r1_gnt, r1_wack, r1_rvalid, r1_done, r1_rdata};
      if (mon_other != '0) check("nonowner_zero", mon_other, 0);
    end
  end

  // One full transaction; the request must already be driven and the next
  // edge must sample it in IDLE.
  task automatic txn(input int r, input logic [1:0] c, input logic [14:0] a,
                     input logic [15:0] base, input bit stall, input bit mid);
    int wacks = 0;
    int k = 0;
    logic w;
    rbeats = 0;
    if (c == 2'd3) begin
      set_wdata(r, base);
      for (int i = 0; i < 16; i++) wq.push_back(16'(base + i));
    end
    cyc();
    check("grant", get_gnt(r), 1);
    check("loser_gnt", get_gnt(1 - r), 0);
    check("m_cmd_issue", m_cmd, c);
    check("m_addr_issue", m_addr, a);
    exp_owner = r;
    exp_addr  = a;
    if (c == 2'd3) begin
      for (int i = 0; i < 40; i++) begin
        if (m_cmd == 2'd0) break;
        if (get_wack(r)) wacks++;
        if (!mid && i == 0) set_req(r, 2'd0, a);
        if (mid && i == 6)  set_req(r, 2'd0, 15'h1555);
        w = get_wack(r);
        cyc();
        if (w) begin k++; set_wdata(r, 16'(base + k)); end
      end
      check("wr_wack_count", wacks, 16);
      check("wr_wait_nop", m_cmd, 0);
      check("wr_wait_wdata", m_wdata, 0);
      cyc(); cyc();
      check("wr_done_early", get_done(r), 0);
      m_resp = 1'b1;
      cyc();
      m_resp = 1'b0;
      check("wr_done", get_done(r), 1);
      check("wq_empty", wq.size(), 0);
    end else begin
      set_req(r, 2'd0, a);
      cyc();
      check("rd_wait_nop", m_cmd, 0);
      if (stall) repeat (3) cyc();
      for (int b = 0; b < 16; b++) begin
        if (stall && b > 0) begin m_resp = 1'b0; cyc(); cyc(); end
        m_resp = 1'b1;
        m_rdata = 16'(base + b);
        rq.push_back(16'(base + b));
        cyc();
      end
      m_resp = 1'b0;
      m_rdata = '0;
      check("rd_done_early", get_done(r), 0);
      cyc();
      check("rd_done", get_done(r), 1);
      check("rd_beat_count", rbeats, 16);
      check("rq_empty", rq.size(), 0);
    end
    cyc();
    check("idle_gnt", get_gnt(r), 0);
    check("idle_done", get_done(r), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    r0_cmd = '0; r1_cmd = '0; r0_addr = '0; r1_addr = '0;
    r0_wdata = '0; r1_wdata = '0; m_resp = 1'b0; m_rdata = '0;
    repeat (3) cyc();
    check("reset_outputs", any_out(), 0);
    rst_n = 1'b1;
    cyc();
    check("idle_outputs", any_out(), 0);

    // Single read, then single write (pointer R1 -> R0).
    set_req(0, 2'd2, 15'h1234);
    txn(0, 2'd2, 15'h1234, 16'h0000, 1'b0, 1'b0);
    set_req(1, 2'd3, 15'h7FFF);
    txn(1, 2'd3, 15'h7FFF, 16'hA000, 1'b0, 1'b0);

    // Contention with pointer at R0, loser served right after DONE.
    set_req(0, 2'd2, 15'h0100);
    set_req(1, 2'd2, 15'h0200);
    txn(0, 2'd2, 15'h0100, 16'h1100, 1'b0, 1'b0);
    txn(1, 2'd2, 15'h0200, 16'h2200, 1'b0, 1'b0);

    // Owner drops and changes its request mid-write; pointer becomes R1.
    set_req(0, 2'd3, 15'h0ABC);
    txn(0, 2'd3, 15'h0ABC, 16'h5000, 1'b0, 1'b1);

    // Contention with pointer at R1: stalled read wins, then the write.
    set_req(0, 2'd3, 15'h0111);
    set_req(1, 2'd2, 15'h0222);
    txn(1, 2'd2, 15'h0222, 16'h0100, 1'b1, 1'b0);
    txn(0, 2'd3, 15'h0111, 16'h3000, 1'b0, 1'b0);

    // Reset during read beat 7 (pointer is R1 here).
    rbeats = 0;
    set_req(0, 2'd2, 15'h0333);
    cyc();
    check("rst_txn_grant", r0_gnt, 1);
    exp_owner = 0;
    exp_addr = 15'h0333;
    set_req(0, 2'd0, 15'h0333);
    cyc();
    for (int b = 0; b < 8; b++) begin
      m_resp = 1'b1;
      m_rdata = 16'(16'h0700 + b);
      rq.push_back(16'(16'h0700 + b));
      if (b < 7) cyc();
    end
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", any_out(), 0);
    check("rst_beats_before", rbeats, 7);
    rq.delete();
    m_resp = 1'b0;
    m_rdata = '0;
    cyc();
    check("reset_m_cmd_nop", m_cmd, 0);
    rst_n = 1'b1;
    cyc();

    // Pointer must be back at R0 after reset.
    set_req(0, 2'd2, 15'h0444);
    set_req(1, 2'd2, 15'h0555);
    txn(0, 2'd2, 15'h0444, 16'h4400, 1'b0, 1'b0);
    txn(1, 2'd2, 15'h0555, 16'h5500, 1'b0, 1'b0);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
